// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared types and constants for the multi-read-port register file.
package reg_file_mp_pkg;
  typedef enum logic {CLEAR, IDLE} state_e;
  localparam int RD_PORTS_MAX = 4;
  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one registered read port; REG_FILE_MP_BYPASS_EN adds same-cycle write forwarding.
module reg_file_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            en_i,
  input  logic [DATA_WIDTH-1:0]           word_i,
`ifdef REG_FILE_MP_BYPASS_EN
  input  logic                            hit_i,
  input  logic [DATA_WIDTH-1:0]           wr_data_i,
  input  logic [be_width(DATA_WIDTH)-1:0] wr_be_i,
`endif
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic                            valid_o
);
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
`ifdef REG_FILE_MP_BYPASS_EN
  always_comb begin
    data_d = word_i;
    for (int b = 0; b < be_width(DATA_WIDTH); b++)
      data_d[8*b +: 8] = (hit_i && wr_be_i[b]) ? wr_data_i[8*b +: 8] : word_i[8*b +: 8];
  end
`else
  always_comb data_d = word_i;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en_i;
      if (en_i) data_q <= data_d;
    end
  end
  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with byte-enable writes and a hardware clear sweep.
// Build option REG_FILE_MP_BYPASS_EN forwards a same-cycle write into colliding reads.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int RD_PORTS   = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [be_width(DATA_WIDTH)-1:0]  wr_be,
  input  logic [RD_PORTS-1:0]              rd_en,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [RD_PORTS-1:0]              rd_valid,
  input  logic                             clr,
  output logic                             busy
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  assign busy = (state_q == CLEAR);
  always_comb begin
    state_d   = busy ? (&clr_idx_q ? IDLE : CLEAR) : (clr ? CLEAR : IDLE);
    clr_idx_d = busy ? clr_idx_q + ADDR_WIDTH'(1) : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end
  // Storage is deliberately unreset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (busy) mem_q[clr_idx_q] <= '0;
    else if (wr_en)
      for (int b = 0; b < be_width(DATA_WIDTH); b++)
        if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
  end
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    reg_file_rd_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
      .clk       (clk),
      .reset_n   (reset_n),
      .en_i      (rd_en[p] && !busy),
      .word_i    (mem_q[addr]),
`ifdef REG_FILE_MP_BYPASS_EN
      .hit_i     (wr_en && !busy && (wr_addr == addr)),
      .wr_data_i (wr_data),
      .wr_be_i   (wr_be),
`endif
      .data_o    (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .valid_o   (rd_valid[p])
    );
  end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file with byte-enable writes, registered reads and a hardware clear sweep. It is the storage core for the next-generation FIFO and the small register banks in the peripheral blocks. It replaces the single-port, combinational-read register file wherever more than one consumer reads the same storage, or where storage must start in a known state.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH entries
- RD_PORTS, 2, number of independent read ports, range 1..4
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request, honoured only when busy = 0
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  DATA_WIDTH/8  byte enables; bit i gates wr_data[8i+7:8i]
- rd_en  in  RD_PORTS  per-port read request, honoured only when busy = 0
- rd_addr  in  RD_PORTS*ADDR_WIDTH  packed read addresses; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  RD_PORTS*DATA_WIDTH  packed registered read data, same slicing by DATA_WIDTH
- rd_valid  out  RD_PORTS  one-cycle pulse marking new rd_data on port p
- clr  in  1  single-cycle pulse that starts a clear sweep
- busy  out  1  high while the clear sweep runs

## Operation
- FSM, two states:
  - CLEAR: a counter clr_idx walks 0..DEPTH-1 and writes all-zero to one entry per cycle. At DEPTH-1 the FSM moves to IDLE.
  - IDLE: normal access. clr = 1 moves the FSM to CLEAR with clr_idx = 0.
- Reset assertion: FSM = CLEAR, clr_idx = 0, rd_data = 0, rd_valid = 0, busy = 1. The storage array has no reset; the sweep initialises it.
- busy = 1 exactly when state = CLEAR.
- clr while busy = 1 is ignored; the sweep is not restarted.
- Reset asserted mid-sweep restarts the sweep from 0 after release.
- Write in IDLE with wr_en = 1: each byte whose wr_be bit is set is updated at the clock edge. wr_be = 0 makes the write a no-op.
- Read in IDLE with rd_en[p] = 1: the addressed word is captured into rd_data slice p, and rd_valid[p] = 1 in the next cycle.
- With rd_en[p] = 0, rd_data slice p holds its last value and rd_valid[p] = 0.
- While busy = 1, wr_en and rd_en are ignored: no write, rd_valid = 0, rd_data holds.
- All read ports may address the same entry at once, and each returns identical data.
- Address wrap: none. Every ADDR_WIDTH value is a valid entry.

## Timing
- Read latency: 1 cycle from the rd_en edge to rd_valid/rd_data.
- Write latency: data is visible to a read issued on the cycle after the write.
- Clear duration: exactly DEPTH cycles with busy = 1. After reset release, the first access is accepted in cycle DEPTH.
- clr sampled in IDLE: busy rises on the next cycle and stays high for DEPTH cycles.
- A write and a read to the same address in the same cycle are governed by the Configuration section.

## Configuration
- Macro: REG_FILE_MP_BYPASS_EN.
- Defined: a same-cycle read of the address being written returns the merged word. Enabled bytes come from wr_data; the remaining bytes come from the old contents.
- Undefined: the same-cycle read returns the old contents only; the new value is visible from the next cycle.
- The macro affects the same-address collision case only. Without it, the read path contains no forwarding muxes.

## Structure
- Package reg_file_mp_pkg holds:
  - the FSM state enum typedef (CLEAR, IDLE);
  - a localparam function computing byte-enable width from DATA_WIDTH;
  - the RD_PORTS upper-limit constant.
- Sub-module reg_file_rd_port: one registered read port, holding the rd_data/rd_valid registers and the optional bypass merge. It is instantiated RD_PORTS times in a generate loop.
- The top level contains the storage array, the write logic, the clear FSM and the counter.

## Test plan
- Reset release -> busy = 1 for exactly 8 cycles, rd_valid stays 0. Then read all 8 addresses -> each returns 0x0000.
- Write 0xABCD to addr 3 with wr_be = 2'b11, then write 0x1234 to addr 3 with wr_be = 2'b01. Read addr 3 -> 0xAB34, rd_valid pulses 1 cycle after rd_en.
- Port 0 reads addr 5 and port 1 reads addr 5 in the same cycle after writing 0x5A5A -> both ports return 0x5A5A, both rd_valid bits high for one cycle.
- Write 0x00FF to addr 2 and read addr 2 in the same cycle, with old contents 0x1111:
  - with REG_FILE_MP_BYPASS_EN -> 0x00FF;
  - without -> 0x1111, then 0x00FF on the next read.
- Pulse clr after filling all entries. Issue wr_en and rd_en during busy -> ignored, no rd_valid. Pulse clr again mid-sweep -> busy lasts 8 cycles total. Afterwards all entries read 0.
- Assert reset_n low at sweep cycle 4, release -> busy is high for a full 8 cycles, and rd_data = 0 during reset.
